// File: rtl/calc_pkg.sv
// Shared keypad/calculator definitions: key vector width, digit width and encoder states.
package calc_pkg;

  localparam int KEY_W   = 10;
  localparam int DIGIT_W = 4;

  localparam logic [KEY_W-1:0] KEY_NONE = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    HOLD  = 2'd2
  } key_state_e;

endpackage

// File: rtl/onehot_n_decode.sv
// Combinational decode of an active-low key vector into index, none and multi flags.
module onehot_n_decode
  import calc_pkg::*;
(
  input  logic [KEY_W-1:0]   key_n,
  output logic [DIGIT_W-1:0] index,
  output logic               none,
  output logic               multi
);

  logic [KEY_W-1:0] low;

  always_comb begin
    low   = ~key_n;
    none  = (low == '0);
    // Clearing the lowest set bit leaves something only when two or more keys are down.
    multi = ((low & (low - KEY_W'(1))) != '0);
    index = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (low[i]) index = DIGIT_W'(i);
    end
  end

endmodule

// File: rtl/keypad_encoder_v.sv
// Keypad front end: sync, debounce and validate a 10-key active-low keypad into DIGIT/VALID.
// Define KEY_REPEAT_EN to add an auto-repeat strobe every REPEAT_CYCLES while a key is held.
module keypad_encoder_v
  import calc_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1,
  parameter int unsigned REPEAT_CYCLES = 50000000,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [KEY_W-1:0]   KEY_N,
  output logic [DIGIT_W-1:0] DIGIT,
  output logic               VALID,
  output logic               HELD,
  output logic               ERR
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES);

  logic [KEY_W-1:0]   s1;
  logic [KEY_W-1:0]   ks;
  logic [1:0]         fill;
  logic               wait_rel;
  key_state_e         state;
  logic [DIGIT_W-1:0] cand;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic [DIGIT_W-1:0] ks_idx;
  logic               ks_none;
  logic               ks_multi;
  logic               ks_one;
  logic               ks_same;

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES);
  logic [CNT_W-1:0] rpt;
  logic [CNT_W-1:0] rpt_nxt;
  assign rpt_nxt = rpt + CNT_W'(1);
`endif

  onehot_n_decode u_dec (
    .key_n (ks),
    .index (ks_idx),
    .none  (ks_none),
    .multi (ks_multi)
  );

  assign ks_one  = !ks_none && !ks_multi;
  assign ks_same = ks_one && (ks_idx == cand);
  assign cnt_nxt = cnt + CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1       <= KEY_NONE;
      ks       <= KEY_NONE;
      fill     <= '0;
      wait_rel <= 1'b1;
      state    <= IDLE;
      cand     <= '0;
      cnt      <= '0;
      DIGIT    <= '0;
      VALID    <= 1'b0;
      HELD     <= 1'b0;
      ERR      <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt      <= '0;
`endif
    end else begin
      // Stage boundary: raw pad -> s1 -> ks; fill marks when ks reflects real input again.
      s1    <= KEY_N;
      ks    <= s1;
      fill  <= {fill[0], 1'b1};
      ERR   <= ks_multi;
      VALID <= 1'b0;

      case (state)
        IDLE: begin
          // After reset a key still down must be released before it can be accepted.
          if (wait_rel) begin
            if (fill[1] && ks_none) wait_rel <= 1'b0;
          end else if (ks_one) begin
            cand <= ks_idx;
            cnt  <= CNT_W'(1);
            if (STABLE_CYCLES <= 1) begin
              state <= HOLD;
              HELD  <= 1'b1;
              VALID <= 1'b1;
              DIGIT <= ks_idx;
`ifdef KEY_REPEAT_EN
              rpt   <= '0;
`endif
            end else begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (ks_same) begin
            cnt <= cnt_nxt;
            if (cnt_nxt == STABLE_LAST) begin
              state <= HOLD;
              HELD  <= 1'b1;
              VALID <= 1'b1;
              DIGIT <= cand;
`ifdef KEY_REPEAT_EN
              rpt   <= '0;
`endif
            end
          end else begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        HOLD: begin
          if (ks_none) begin
            state <= IDLE;
            HELD  <= 1'b0;
            cnt   <= '0;
`ifdef KEY_REPEAT_EN
            rpt   <= '0;
          end else if (ks_same) begin
            if (rpt_nxt == REPEAT_LAST) begin
              VALID <= 1'b1;
              DIGIT <= cand;
              rpt   <= '0;
            end else begin
              rpt <= rpt_nxt;
            end
          end else begin
            rpt <= '0;
`endif
          end
        end

        default: begin
          state <= IDLE;
          HELD  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_encoder_v.sv
// Directed bench for keypad_encoder_v: one instance with STABLE_CYCLES=1, one with 4, shared keypad.
module tb_keypad_encoder_v;
  import calc_pkg::*;

  localparam logic [KEY_W-1:0] K0 = 10'b1111111110;
  localparam logic [KEY_W-1:0] K2 = 10'b1111111011;
  localparam logic [KEY_W-1:0] K4 = 10'b1111101111;
  localparam logic [KEY_W-1:0] K5 = 10'b1111011111;
  localparam logic [KEY_W-1:0] K7 = 10'b1101111111;
  localparam logic [KEY_W-1:0] K8 = 10'b1011111111;
  localparam logic [KEY_W-1:0] K9 = 10'b0111111111;
  localparam logic [KEY_W-1:0] KM = 10'b0111110111;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic [KEY_W-1:0]   KEY_N = KEY_NONE;

  logic [DIGIT_W-1:0] digit_a, digit_b;
  logic               valid_a, valid_b;
  logic               held_a, held_b;
  logic               err_a, err_b;

  int total = 0;
  int bad   = 0;
  int na    = 0;
  int nb    = 0;
  logic [DIGIT_W-1:0] last_a = '0;
  logic [DIGIT_W-1:0] last_b = '0;

  keypad_encoder_v #(.STABLE_CYCLES(1), .REPEAT_CYCLES(10), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .KEY_N(KEY_N),
    .DIGIT(digit_a), .VALID(valid_a), .HELD(held_a), .ERR(err_a)
  );

  keypad_encoder_v #(.STABLE_CYCLES(4), .REPEAT_CYCLES(10), .CNT_W(16)) dut_b (
    .CLK(CLK), .RST(RST), .KEY_N(KEY_N),
    .DIGIT(digit_b), .VALID(valid_b), .HELD(held_b), .ERR(err_b)
  );

  always #10 CLK = ~CLK;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      if (valid_a) begin na++; last_a = digit_a; end
      if (valid_b) begin nb++; last_b = digit_b; end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and idle
    RST = 1'b1; KEY_N = KEY_NONE;
    step(2);
    chk("rst_digit_a", 32'(digit_a), 0);
    chk("rst_valid_a", 32'(valid_a), 0);
    chk("rst_held_a",  32'(held_a), 0);
    chk("rst_err_a",   32'(err_a), 0);
    chk("rst_digit_b", 32'(digit_b), 0);
    chk("rst_valid_b", 32'(valid_b), 0);
    RST = 1'b0;
    na = 0; nb = 0;
    step(20);
    chk("idle_na", na, 0);
    chk("idle_nb", nb, 0);

    // Single one-cycle press of key 0, exact latency on the STABLE_CYCLES=1 instance
    KEY_N = K0;
    step(1);
    KEY_N = KEY_NONE;
    step(1);
    chk("k0_early_valid", 32'(valid_a), 0);
    step(1);
    chk("k0_valid", 32'(valid_a), 1);
    chk("k0_digit", 32'(digit_a), 0);
    chk("k0_held", 32'(held_a), 1);
    step(1);
    chk("k0_valid_off", 32'(valid_a), 0);
    chk("k0_held_off", 32'(held_a), 0);
    step(4);

    KEY_N = K8;
    step(1);
    KEY_N = KEY_NONE;
    step(2);
    chk("k8_valid", 32'(valid_a), 1);
    chk("k8_digit", 32'(digit_a), 8);
    step(4);
    chk("single_na", na, 2);
    chk("single_nb", nb, 0);

    // Bounce: key 7 low 3, high 1, low 6
    na = 0; nb = 0;
    KEY_N = K7;       step(3);
    KEY_N = KEY_NONE; step(1);
    KEY_N = K7;       step(5);
    chk("bnc_pre_valid_b", 32'(valid_b), 0);
    step(1);
    KEY_N = KEY_NONE;
    chk("bnc_valid_b", 32'(valid_b), 1);
    chk("bnc_digit_b", 32'(digit_b), 7);
    chk("bnc_held_b0", 32'(held_b), 1);
    step(1);
    chk("bnc_held_b1", 32'(held_b), 1);
    chk("bnc_valid_b_off", 32'(valid_b), 0);
    step(1);
    chk("bnc_held_b2", 32'(held_b), 1);
    step(1);
    chk("bnc_held_b3", 32'(held_b), 0);
    step(3);
    chk("bnc_nb", nb, 1);
    chk("bnc_na", na, 2);

    // Multi-key: keys 9 and 3 for 5 cycles, ERR one cycle behind ks
    na = 0; nb = 0;
    KEY_N = KM;
    for (int j = 1; j <= 8; j++) begin
      step(1);
      if (j == 5) KEY_N = KEY_NONE;
      chk($sformatf("multi_err_a_%0d", j), 32'(err_a), (j >= 3 && j <= 7) ? 1 : 0);
      chk($sformatf("multi_err_b_%0d", j), 32'(err_b), (j >= 3 && j <= 7) ? 1 : 0);
    end
    chk("multi_na", na, 0);
    chk("multi_nb", nb, 0);
    KEY_N = K4;       step(5);
    KEY_N = KEY_NONE; step(6);
    chk("k4_na", na, 1);
    chk("k4_nb", nb, 1);
    chk("k4_digit_a", 32'(last_a), 4);
    chk("k4_digit_b", 32'(last_b), 4);

    // Key change without release: 8 then 9, 9 only after release
    na = 0; nb = 0;
    KEY_N = K8;       step(6);
    KEY_N = K9;       step(6);
    KEY_N = KEY_NONE; step(4);
    chk("chg_na", na, 1);
    chk("chg_nb", nb, 1);
    chk("chg_digit_a", 32'(last_a), 8);
    chk("chg_digit_b", 32'(last_b), 8);
    chk("chg_held_a", 32'(held_a), 0);
    KEY_N = K9;       step(6);
    KEY_N = KEY_NONE; step(4);
    chk("rep9_na", na, 2);
    chk("rep9_nb", nb, 2);
    chk("rep9_digit_a", 32'(last_a), 9);
    chk("rep9_digit_b", 32'(last_b), 9);

    // Reset while the STABLE_CYCLES=4 instance is in CHECK with key 2 held
    KEY_N = K2;
    step(3);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("mid_rst_held_a", 32'(held_a), 0);
    chk("mid_rst_digit_a", 32'(digit_a), 0);
    chk("mid_rst_valid_b", 32'(valid_b), 0);
    na = 0; nb = 0;
    step(10);
    chk("mid_rst_na", na, 0);
    chk("mid_rst_nb", nb, 0);
    KEY_N = KEY_NONE; step(4);
    KEY_N = K2;       step(6);
    KEY_N = KEY_NONE; step(4);
    chk("repress_na", na, 1);
    chk("repress_nb", nb, 1);
    chk("repress_digit_a", 32'(last_a), 2);
    chk("repress_digit_b", 32'(last_b), 2);

    // Long hold of key 5 for 35 cycles
    na = 0; nb = 0;
    KEY_N = K5;       step(35);
    KEY_N = KEY_NONE; step(5);
`ifdef KEY_REPEAT_EN
    chk("hold5_na", na, 4);
    chk("hold5_nb", nb, 4);
`else
    chk("hold5_na", na, 1);
    chk("hold5_nb", nb, 1);
`endif
    chk("hold5_digit_a", 32'(last_a), 5);
    chk("hold5_digit_b", 32'(last_b), 5);
    chk("hold5_held_a", 32'(held_a), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_encoder_v.md
Name: keypad_encoder_v

Overview:
- Upstream front end for the 4-bit add/sub calculator top.
- Takes one raw 10-key active-low one-hot operand keypad (key i low = digit i).
- Synchronises, debounces and validates the keypad input.
- Emits a 4-bit binary digit with a single-cycle VALID strobe per press, which the calculator's operand latch consumes.
- One instance per operand (A, B).

Parameters:
- STABLE_CYCLES, 1: consecutive identical one-hot samples required before a press is accepted; legal range 1..65535.
- REPEAT_CYCLES, 50000000: hold time, in cycles, before an auto-repeat strobe. Used only with KEY_REPEAT_EN.
- CNT_W, 16: debounce/repeat counter width. Must satisfy 2^CNT_W > max(STABLE_CYCLES, REPEAT_CYCLES) when repeat is enabled; the instantiating top sets it to 26 for the default REPEAT_CYCLES.

Ports:
- CLK  input  1  system clock (50 MHz); all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- KEY_N  input  10  raw keypad, active low; 10'h3FF means no key.
- DIGIT  output  4  accepted digit 0..9. Holds its last accepted value until the next accept.
- VALID  output  1  one-cycle strobe; DIGIT is valid in the same cycle.
- HELD  output  1  high while an accepted key is still pressed.
- ERR  output  1  registered; high in any cycle where the synchronised input has more than one bit low.

Behaviour:
- Interface (already decided): one clock CLK; reset RST is synchronous and active-high.
- Reset: on any edge with RST=1:
  - DIGIT=0, VALID=0, HELD=0, ERR=0.
  - Both synchroniser stages = 10'h3FF.
  - State=IDLE; counters=0.
  - Applies mid-press: the press is discarded, and no VALID is issued until the key is released and pressed again.
- Synchroniser: two flops, KEY_N → s1 → ks. All decisions use ks only.
- Decode of ks:
  - NONE = all ones.
  - ONE(i) = exactly bit i low.
  - MULTI = two or more bits low.
- States IDLE, CHECK, HOLD:
  - IDLE:
    - ONE(i): cand=i, cnt=1. If STABLE_CYCLES==1, go to HOLD and assert VALID on this edge with DIGIT=i. Otherwise go to CHECK.
    - NONE or MULTI: stay in IDLE.
  - CHECK:
    - ONE(cand): cnt++. When cnt reaches STABLE_CYCLES, go to HOLD and issue VALID with DIGIT=cand.
    - Any other value (NONE, a different ONE, MULTI): return to IDLE. No VALID.
  - HOLD:
    - HELD=1.
    - NONE: go to IDLE.
    - ONE(cand): stay.
    - MULTI or a different ONE: stay in HOLD with no new VALID. A key change is only accepted after a full release.
- Latency: a key first sampled into s1 at edge 0 produces VALID on the cycle after edge STABLE_CYCLES+1. With STABLE_CYCLES=1, a key held low for one cycle (20 ns) is accepted.
- VALID is never high on two consecutive cycles, except via repeat.
- DIGIT and VALID update on the same edge.
- ERR is independent of state and lags ks by one cycle.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In HOLD, a repeat counter starts at 0 on entry.
  - When it reaches REPEAT_CYCLES, VALID pulses again with the same DIGIT and the counter reloads to 0.
  - Release, MULTI or RST clears the counter.
- Undefined: exactly one VALID per press. The repeat counter and its logic are absent.

Decomposition:
- Shared package calc_pkg holds:
  - KEY_W=10, DIGIT_W=4, KEY_NONE=10'h3FF.
  - State encoding (IDLE=2'd0, CHECK=2'd1, HOLD=2'd2).
  - These are reused by the calculator top and its testbench.
- One sub-module, onehot_n_decode:
  - Combinational; maps a 10-bit active-low vector to index[3:0], none and multi.
  - Reused by the B-operand instance and the bench checker.

Test Plan:
- Reset / idle: RST=1 for 2 cycles with KEY_N=10'h3FF → DIGIT=0, VALID=0, HELD=0, ERR=0; no strobe over 20 idle cycles.
- Single press:
  - Setup: STABLE_CYCLES=1; KEY_N=10'b1111111110 for 1 cycle, then 3FF.
  - Expect: exactly one VALID with DIGIT=0 on the cycle after edge 2.
  - Then KEY_N=10'b1011111111 → one VALID with DIGIT=8.
- Bounce rejection:
  - Setup: STABLE_CYCLES=4; key 7 (10'b1101111111) low 3 cycles, high 1, low 6.
  - Expect: no VALID from the first burst; one VALID with DIGIT=7 from the second; HELD=1 until release.
- Multi-key:
  - 10'b0111110111 (keys 9 and 3) for 5 cycles → ERR=1 for 5 cycles, lagging ks by one cycle; VALID=0.
  - Then key 4 alone → VALID with DIGIT=4.
- Key change without release: hold 8, then switch directly to 9 → only DIGIT=8 is strobed; 9 is accepted only after 3FF, then 9 pressed.
- Reset mid-CHECK and repeat:
  - Assert RST in CHECK with the key held → no VALID until release and re-press.
  - With KEY_REPEAT_EN, REPEAT_CYCLES=10, key 5 held 35 cycles → 4 strobes, all DIGIT=5.
